// File: rtl/adc_spi_ctrl.sv
// rtl/adc_spi_ctrl.sv - free-running conversion/readout frame sequencer for an SPI SAR ADC
//
// Purpose: repeatedly runs one ADC frame: latch the channel config, pulse
// CONVST, wait out the conversion, then clock 12 SCK pulses. During those
// pulses the 6-bit config goes out on SDI and the previous conversion comes
// back on SDO. Each frame ends with a one-cycle result strobe.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   chan         in   channel requested for the next frame (sampled in IDLE only)
//   adc_convst   out  conversion start, high for CONV_HI cycles per frame
//   adc_sck      out  serial clock, 12 pulses per frame, idles low
//   adc_sdi      out  config word to the ADC, MSB first
//   adc_sdo      in   conversion data from the ADC, MSB first
//   result       out  last completed conversion
//   result_chan  out  channel that result belongs to
//   result_valid out  one-cycle strobe marking a new result
module adc_spi_ctrl #(
  parameter int CLK_HALF  = 2,
  parameter int CONV_HI   = 2,
  parameter int CONV_WAIT = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  chan,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] result,
  output logic [2:0]  result_chan,
  output logic        result_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One counter serves CONV, WAIT and each SCK half-period, so size it for the longest.
  localparam int CNT_MAX_A = (CONV_HI > CONV_WAIT) ? CONV_HI : CONV_WAIT;
  localparam int CNT_MAX   = (CLK_HALF > CNT_MAX_A) ? CLK_HALF : CNT_MAX_A;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // 24 SCK half-periods per frame; odd phases are the high half.
  localparam logic [4:0] LAST_PHASE = 5'd23;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       phase_q, phase_d;
  logic [5:0]       cfg_q, cfg_d;
  logic [5:0]       cfg_sh;
  logic [2:0]       chan_q, chan_d;           // channel encoded in this frame's config
  logic [2:0]       prev_chan_q, prev_chan_d; // channel whose data shifts out this frame
  logic [11:0]      shreg_q, shreg_d;
  logic [11:0]      result_q, result_d;
  logic [2:0]       result_chan_q, result_chan_d;
  logic             convst_q, convst_d;
  logic             sck_q, sck_d;
  logic             sdi_q, sdi_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    phase_d       = phase_q;
    cfg_d         = cfg_q;
    chan_d        = chan_q;
    prev_chan_d   = prev_chan_q;
    shreg_d       = shreg_q;
    result_d      = result_q;
    result_chan_d = result_chan_q;

    case (state_q)
      S_IDLE: begin
        state_d     = S_CONV;
        cfg_d       = {1'b1, chan[0], chan[2], chan[1], 1'b1, 1'b0};
        prev_chan_d = chan_q;
        chan_d      = chan;
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(CONV_HI - 1)) state_d = S_WAIT;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(CONV_WAIT - 1)) begin
          state_d = S_SHIFT;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_HALF - 1)) begin
          // Leaving a low phase means SCK rises on this edge: capture SDO now.
          if (!phase_q[0]) shreg_d = {shreg_q[10:0], adc_sdo};
          if (phase_q == LAST_PHASE) begin
            state_d       = S_DONE;
            result_d      = shreg_q;
            result_chan_d = prev_chan_q;
          end else begin
            phase_d = phase_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so pins never glitch on state decode.
  // Each SCK period (two phases) consumes one config bit; past bit 0 the shift yields zeros.
  always_comb begin
    cfg_sh   = cfg_d << phase_d[4:1];
    convst_d = (state_d == S_CONV);
    sck_d    = (state_d == S_SHIFT) && phase_d[0];
    sdi_d    = (state_d == S_SHIFT) && cfg_sh[5];
    valid_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      cfg_q         <= '0;
      chan_q        <= '0;
      prev_chan_q   <= '0;
      shreg_q       <= '0;
      result_q      <= '0;
      result_chan_q <= '0;
      convst_q      <= 1'b0;
      sck_q         <= 1'b0;
      sdi_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      cfg_q         <= cfg_d;
      chan_q        <= chan_d;
      prev_chan_q   <= prev_chan_d;
      shreg_q       <= shreg_d;
      result_q      <= result_d;
      result_chan_q <= result_chan_d;
      convst_q      <= convst_d;
      sck_q         <= sck_d;
      sdi_q         <= sdi_d;
      valid_q       <= valid_d;
    end
  end

  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;
  assign result       = result_q;
  assign result_chan  = result_chan_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// tb/tb_adc_spi_ctrl.sv - self-checking bench for adc_spi_ctrl
`timescale 1ns/1ps
module tb_adc_spi_ctrl;

  localparam int CH = 2;
  localparam int HI = 2;
  localparam int WT = 80;
  localparam int P  = 2 + HI + WT + 24 * CH;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  chan = 3'd0;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;
  logic [11:0] result;
  logic [2:0]  result_chan;
  logic        result_valid;

  logic        f_convst, f_sck, f_sdi;
  logic [11:0] f_result;
  logic [2:0]  f_result_chan;
  logic        f_valid;
  logic        fast_done = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adc_spi_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .chan(chan),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .result(result), .result_chan(result_chan), .result_valid(result_valid)
  );

  adc_spi_ctrl #(.CLK_HALF(1), .CONV_HI(1), .CONV_WAIT(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .chan(3'd2),
    .adc_convst(f_convst), .adc_sck(f_sck), .adc_sdi(f_sdi), .adc_sdo(1'b1),
    .result(f_result), .result_chan(f_result_chan), .result_valid(f_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Word the emulated ADC converts in frame f after reset.
  function automatic logic [11:0] word_of(input int f);
    case (f)
      1:       return 12'hFFF;
      2:       return 12'h000;
      default: return 12'hA5C;
    endcase
  endfunction

  function automatic logic [5:0] cfg_of(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  // ADC emulator: MSB ready after CONVST, next bit after each SCK rise; records SDI at SCK rises.
  logic [11:0] adc_word = 12'h0;
  logic [11:0] sdi_cap = 12'h0;
  int adc_n = 0;
  int adc_bi = 0;
  logic cv_prev = 1'b0;
  logic sk_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      adc_n = 0; adc_bi = 0; adc_sdo = 1'b0; cv_prev = 1'b0; sk_prev = 1'b0;
    end else begin
      if (adc_convst && !cv_prev) begin
        adc_word = word_of(adc_n);
        adc_n++;
        adc_bi = 0;
        adc_sdo = adc_word[11];
        sdi_cap = 12'h0;
      end else if (adc_sck && !sk_prev) begin
        sdi_cap = {sdi_cap[10:0], adc_sdi};
        adc_bi++;
        adc_sdo = (adc_bi < 12) ? adc_word[11 - adc_bi] : 1'b0;
      end
      cv_prev = adc_convst;
      sk_prev = adc_sck;
    end
  end

  // Reference model: cycles since reset release, decomposed into frame number and offset.
  int t = 0;
  logic [2:0] cof [0:63];
  initial for (int i = 0; i < 64; i++) cof[i] = 3'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) t = 0;
    else          t = t + 1;
  end

  always @(negedge clk) begin
    int f, tf, s, k, g;
    logic [5:0] cw;
    logic e_cv, e_sck, e_sdi, e_v;
    logic [11:0] e_res;
    logic [2:0] e_rc;
    e_cv = 0; e_sck = 0; e_sdi = 0; e_v = 0; e_res = 12'h0; e_rc = 3'd0;
    if (reset_n) begin
      f  = t / P;
      tf = t % P;
      if (tf == 0 && f < 64) cof[f] = chan;
      cw = cfg_of(cof[f % 64]);
      e_cv = (tf >= 1) && (tf <= HI);
      s = tf - (1 + HI + WT);
      if (s >= 0 && s < 24 * CH) begin
        e_sck = ((s / CH) % 2) == 1;
        k = s / (2 * CH);
        e_sdi = (k < 6) ? cw[5 - k] : 1'b0;
      end
      e_v = (tf == P - 1);
      g = e_v ? f : f - 1;
      e_res = (g < 0) ? 12'h0 : word_of(g);
      e_rc  = (g < 1) ? 3'd0 : cof[(g - 1) % 64];
    end
    check("m_convst", adc_convst, e_cv);
    check("m_sck", adc_sck, e_sck);
    check("m_sdi", adc_sdi, e_sdi);
    check("m_valid", result_valid, e_v);
    check("m_result", result, e_res);
    check("m_result_chan", result_chan, e_rc);
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!result_valid && n < 400);
    check("valid_seen", result_valid, 1'b1);
  endtask

  task automatic wait_sck_rises(input int want);
    int cnt, n;
    logic prev;
    cnt = 0; n = 0; prev = adc_sck;
    while (cnt < want && n < 400) begin
      @(negedge clk); n++;
      if (adc_sck && !prev) cnt++;
      prev = adc_sck;
    end
    check("sck_rises_seen", cnt, want);
  endtask

  // Short-frame instance: period, pulse count and strobe width.
  initial begin
    int n, rises;
    logic prev;
    @(posedge reset_n);
    n = 0;
    do begin @(negedge clk); n++; end while (!f_valid && n < 100);
    check("fast_first_period", n, 28);
    for (int fr = 0; fr < 3; fr++) begin
      n = 0; rises = 0; prev = f_sck;
      @(negedge clk); n++;
      check("fast_valid_width", f_valid, 1'b0);
      if (f_sck && !prev) rises++;
      prev = f_sck;
      while (!f_valid && n < 100) begin
        @(negedge clk); n++;
        if (f_sck && !prev) rises++;
        prev = f_sck;
      end
      check("fast_period", n, 28);
      check("fast_sck_pulses", rises, 12);
      check("fast_result", f_result, 12'hFFF);
    end
    fast_done = 1'b1;
  end

  initial begin
    int n;
    reset_n = 1'b0;
    chan = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_convst", adc_convst, 1'b0);
    check("rst_sck", adc_sck, 1'b0);
    check("rst_sdi", adc_sdi, 1'b0);
    check("rst_result", result, 12'h0);
    check("rst_result_chan", result_chan, 3'd0);
    check("rst_valid", result_valid, 1'b0);
    reset_n = 1'b1;

    wait_valid(n);
    check("f0_latency", n, 132);
    check("f0_result", result, 12'hA5C);
    check("f0_chan", result_chan, 3'd0);
    #1 chan = 3'd6;

    wait_valid(n);
    check("f1_period", n, 132);
    check("f1_result", result, 12'hFFF);
    check("f1_chan", result_chan, 3'd5);
    check("f1_sdi_bits_ch6", sdi_cap, 12'hB80);
    #1 chan = 3'd3;

    wait_sck_rises(1);
    #1 chan = 3'd7;
    wait_valid(n);
    check("f2_result", result, 12'h000);
    check("f2_chan", result_chan, 3'd6);
    check("f2_sdi_bits_ch3", sdi_cap, 12'hD80);

    wait_valid(n);
    check("f3_period", n, 132);
    check("f3_result", result, 12'hA5C);
    check("f3_chan", result_chan, 3'd3);
    check("f3_sdi_bits_ch7", sdi_cap, 12'hF80);

    wait_sck_rises(6);
    #1 reset_n = 1'b0;
    #1;
    check("abort_sck", adc_sck, 1'b0);
    check("abort_convst", adc_convst, 1'b0);
    check("abort_sdi", adc_sdi, 1'b0);
    check("abort_result", result, 12'h0);
    check("abort_valid", result_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    wait_valid(n);
    check("rf_latency", n, 132);
    check("rf_result", result, 12'hA5C);
    check("rf_chan", result_chan, 3'd0);

    n = 0;
    while (!fast_done && n < 1000) begin @(negedge clk); n++; end
    check("fast_done", fast_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
